i2s_tx: RTL and testbench

- I2S bus master transmitter: serialises left/right audio sample pairs onto i2s_clk / i2s_ws / i2s_din. It generates the bit clock itself from clk.
- Counterpart of the i2s_rx receiver. Used as an on-chip/FPGA audio source feeding the FM transmitter's I2S input, and as the bench stimulus generator for that input.
- Supports both framing modes of the receiver: standard I2S (one-bit delay) and left-justified.

---
 rtl/i2s_tx.sv | 177 +++++++++++++++++
 tb/tb_i2s_tx.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/i2s_tx.sv
// i2s_tx: I2S bus-master transmitter with standard (one-bit delay) or left-justified framing.
// Derives the bit clock from clk and serialises left/right sample pairs MSB first.
module i2s_tx #(
  parameter int DW       = 16,
  parameter int HALF_DIV = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          enable,
  input  logic          ws_align,
  input  logic [DW-1:0] din_left,
  input  logic [DW-1:0] din_right,
  input  logic          din_valid,
  output logic          din_ready,
  output logic          i2s_clk,
  output logic          i2s_ws,
  output logic          i2s_din,
  output logic          frame_start,
  output logic          underrun
);

  localparam int FW = 2 * DW;
  localparam int CW = (HALF_DIV > 1) ? $clog2(HALF_DIV) : 1;
  localparam int BW = $clog2(FW);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  state_t        state_reg, state_next;
  logic [CW-1:0] div_cnt_reg, div_cnt_next;
  logic [BW-1:0] bit_reg, bit_next;
  logic          sclk_reg, sclk_next;
  logic          ws_reg, ws_next;
  logic          sd_reg, sd_next;
  logic          fs_reg, fs_next;
  logic          ur_reg, ur_next;
  logic [FW-1:0] hold_reg, hold_next;
  logic          full_reg, full_next;
  logic [FW-1:0] shift_reg, shift_next;
  // Whole pair of the current frame, replayed on underrun and source of the carried-over LSB.
  logic [FW-1:0] frame_reg, frame_next;
  logic          align_reg, align_next;

  logic          tc;
  logic          fall;
  logic          accept;
  logic          load;
  logic [FW-1:0] load_data;
  logic [BW-1:0] bit_inc;

  assign tc        = (div_cnt_reg == CW'(HALF_DIV - 1));
  assign fall      = tc & sclk_reg;
  assign accept    = din_valid & ~full_reg;
  assign load_data = full_reg ? hold_reg : frame_reg;
  assign bit_inc   = bit_reg + BW'(1);

  always_comb begin
    state_next   = state_reg;
    div_cnt_next = div_cnt_reg;
    bit_next     = bit_reg;
    sclk_next    = sclk_reg;
    ws_next      = ws_reg;
    sd_next      = sd_reg;
    fs_next      = 1'b0;
    ur_next      = 1'b0;
    shift_next   = shift_reg;
    frame_next   = frame_reg;
    align_next   = align_reg;
    load         = 1'b0;

    case (state_reg)
      IDLE: begin
        div_cnt_next = '0;
        sclk_next    = 1'b0;
        bit_next     = '0;
        ws_next      = 1'b0;
        sd_next      = 1'b0;
        if (enable) begin
          load       = 1'b1;
          state_next = RUN;
        end
      end
      RUN, DRAIN: begin
        if (tc) begin
          div_cnt_next = '0;
          sclk_next    = ~sclk_reg;
        end else begin
          div_cnt_next = div_cnt_reg + CW'(1);
        end
        if (fall) begin
          if (state_reg == DRAIN) begin
            state_next = IDLE;
            ws_next    = 1'b0;
            sd_next    = 1'b0;
          end else if (bit_reg == BW'(FW - 1)) begin
            bit_next = '0;
            if (enable) begin
              load = 1'b1;
            end else if (align_reg) begin
              state_next = IDLE;
              ws_next    = 1'b0;
              sd_next    = 1'b0;
            end else begin
              // Standard framing still owes the right LSB one slot after the frame.
              state_next = DRAIN;
              ws_next    = 1'b0;
              sd_next    = frame_reg[0];
            end
          end else begin
            bit_next   = bit_inc;
            ws_next    = (bit_inc >= BW'(DW));
            sd_next    = align_reg ? shift_reg[FW-2] : shift_reg[FW-1];
            shift_next = shift_reg << 1;
          end
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase

    if (load) begin
      shift_next = load_data;
      frame_next = load_data;
      align_next = ws_align;
      fs_next    = 1'b1;
      ur_next    = ~full_reg;
      bit_next   = '0;
      ws_next    = 1'b0;
      sd_next    = ws_align ? load_data[FW-1]
                            : ((state_reg == IDLE) ? 1'b0 : frame_reg[0]);
    end
  end

  // A pair arriving in the load cycle is stored after the load has taken the old contents.
  assign full_next = accept ? 1'b1 : (load ? 1'b0 : full_reg);
  assign hold_next = accept ? {din_left, din_right} : hold_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg   <= IDLE;
      div_cnt_reg <= '0;
      bit_reg     <= '0;
      sclk_reg    <= 1'b0;
      ws_reg      <= 1'b0;
      sd_reg      <= 1'b0;
      fs_reg      <= 1'b0;
      ur_reg      <= 1'b0;
      hold_reg    <= '0;
      full_reg    <= 1'b0;
      shift_reg   <= '0;
      frame_reg   <= '0;
      align_reg   <= 1'b0;
    end else begin
      state_reg   <= state_next;
      div_cnt_reg <= div_cnt_next;
      bit_reg     <= bit_next;
      sclk_reg    <= sclk_next;
      ws_reg      <= ws_next;
      sd_reg      <= sd_next;
      fs_reg      <= fs_next;
      ur_reg      <= ur_next;
      hold_reg    <= hold_next;
      full_reg    <= full_next;
      shift_reg   <= shift_next;
      frame_reg   <= frame_next;
      align_reg   <= align_next;
    end
  end

  assign din_ready   = ~full_reg;
  assign i2s_clk     = sclk_reg;
  assign i2s_ws      = ws_reg;
  assign i2s_din     = sd_reg;
  assign frame_start = fs_reg;
  assign underrun    = ur_reg;

endmodule

// File: tb/tb_i2s_tx.sv
// Scoreboard bench for i2s_tx: frames captured on i2s_clk rising edges are checked against queued expectations.
module tb_i2s_tx;

  localparam int DW = 16;
  localparam int HD = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          enable = 1'b0;
  logic          ws_align = 1'b0;
  logic [DW-1:0] din_left = '0;
  logic [DW-1:0] din_right = '0;
  logic          din_valid = 1'b0;
  logic          din_ready, i2s_clk, i2s_ws, i2s_din, frame_start, underrun;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    logic [31:0] data;
    logic        ur;
    logic        cont;
  } exp_t;

  exp_t sb[$];

  always #5 clk = ~clk;

  i2s_tx #(.DW(DW), .HALF_DIV(HD)) dut (
    .clk        (clk),
    .rst        (rst),
    .enable     (enable),
    .ws_align   (ws_align),
    .din_left   (din_left),
    .din_right  (din_right),
    .din_valid  (din_valid),
    .din_ready  (din_ready),
    .i2s_clk    (i2s_clk),
    .i2s_ws     (i2s_ws),
    .i2s_din    (i2s_din),
    .frame_start(frame_start),
    .underrun   (underrun)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, req);
    end
  endtask

  task automatic timeout(input string name);
    n_cmp++;
    n_err++;
    $display("FAIL %s: timed out waiting for DUT", name);
  endtask

  // Called at a negedge with din_valid already high; returns once the pair is taken.
  task automatic wait_accept(output int waited);
    waited = 0;
    while (!din_ready && waited < 1000) begin
      @(negedge clk);
      waited++;
    end
    if (!din_ready) timeout("accept");
    @(posedge clk);
    #1 din_valid = 1'b0;
    $display("accepted L=%h R=%h after %0d clks", din_left, din_right, waited);
  endtask

  task automatic send(input logic [DW-1:0] l, input logic [DW-1:0] r, output int waited);
    @(negedge clk);
    din_left  = l;
    din_right = r;
    din_valid = 1'b1;
    wait_accept(waited);
  endtask

  task automatic wait_fs(input string name);
    int t;
    t = 0;
    do begin
      @(negedge clk);
      t++;
    end while (!frame_start && t < 1000);
    if (!frame_start) timeout(name);
  endtask

  // Entered at clk 10 of the final frame; checks the last bit, the 4 clks after it, then quiet.
  task automatic check_tail(input string name, input logic [2:0] pre,
                            input logic [2:0] t0, input logic [2:0] t1,
                            input logic [2:0] t2, input logic [2:0] t3);
    logic [2:0] tl [4];
    tl[0] = t0; tl[1] = t1; tl[2] = t2; tl[3] = t3;
    repeat (117) @(negedge clk);
    check({name, "_last_bit"}, {i2s_clk, i2s_ws, i2s_din}, pre);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check({name, "_after"}, {i2s_clk, i2s_ws, i2s_din}, tl[i]);
    end
    repeat (20) begin
      @(negedge clk);
      check({name, "_parked"}, {i2s_clk, i2s_ws, i2s_din}, 3'b000);
    end
    $display("%s stop sequence checked", name);
  endtask

  initial begin : monitor
    logic        prev_sclk;
    logic        ur_cap;
    logic [31:0] dcap, wcap;
    int          cyc, nbits, abs_cyc, last_fs, gap;
    bit          coll, tim_ok;
    exp_t        e;
    prev_sclk = 1'b0; ur_cap = 1'b0; dcap = '0; wcap = '0;
    cyc = 0; nbits = 0; abs_cyc = 0; last_fs = 0; gap = 0;
    coll = 1'b0; tim_ok = 1'b0;
    forever begin
      @(negedge clk);
      abs_cyc++;
      if (rst) begin
        coll      = 1'b0;
        prev_sclk = 1'b0;
      end else begin
        if (frame_start) begin
          coll    = 1'b1;
          nbits   = 0;
          cyc     = 0;
          tim_ok  = 1'b1;
          ur_cap  = underrun;
          gap     = abs_cyc - last_fs;
          last_fs = abs_cyc;
        end else begin
          cyc++;
        end
        if (coll && i2s_clk && !prev_sclk) begin
          if (cyc != HD + 2 * HD * nbits) tim_ok = 1'b0;
          dcap = {dcap[30:0], i2s_din};
          wcap = {wcap[30:0], i2s_ws};
          nbits++;
          if (nbits == 32) begin
            coll = 1'b0;
            $display("frame data=%h ws=%h underrun=%b gap=%0d", dcap, wcap, ur_cap, gap);
            if (sb.size() == 0) begin
              n_cmp++;
              n_err++;
              $display("FAIL sb_unexpected: got frame %h, expected no frame", dcap);
            end else begin
              e = sb.pop_front();
              check("frame_data", dcap, e.data);
              check("frame_ws", wcap, 32'h0000FFFF);
              check("frame_underrun", {31'd0, ur_cap}, {31'd0, e.ur});
              check("bit_timing", {31'd0, tim_ok}, 32'd1);
              if (e.cont) check("frame_gap", gap, 32'd128);
            end
          end
        end
        prev_sclk = i2s_clk;
      end
    end
  end

  initial begin : stimulus
    int w;

    // Reset state
    repeat (3) @(negedge clk);
    check("reset_outputs", {i2s_clk, i2s_ws, i2s_din, frame_start, underrun}, 5'b00000);
    check("reset_ready", {31'd0, din_ready}, 32'd1);
    rst = 1'b0;
    repeat (5) @(negedge clk);

    // Left-justified, then an underrun frame, then stop without drain
    ws_align = 1'b1;
    send(16'hA5C3, 16'h1235, w);
    sb.push_back('{32'hA5C31235, 1'b0, 1'b0});
    sb.push_back('{32'hA5C31235, 1'b1, 1'b1});
    @(negedge clk);
    enable = 1'b1;
    wait_fs("lj_frame1");
    wait_fs("lj_frame2");
    repeat (10) @(negedge clk);
    enable = 1'b0;
    check_tail("lj_stop", 3'b111, 3'b000, 3'b000, 3'b000, 3'b000);

    // Standard I2S with backpressure, then stop with drain bit
    ws_align = 1'b0;
    send(16'hA5C3, 16'h1235, w);
    @(negedge clk);
    din_left  = 16'h7FFF;
    din_right = 16'h8000;
    din_valid = 1'b1;
    check("bp_ready_full", {31'd0, din_ready}, 32'd0);
    sb.push_back('{32'h52E1891A, 1'b0, 1'b0});
    sb.push_back('{32'hBFFFC000, 1'b0, 1'b1});
    sb.push_back('{32'h0787E1D2, 1'b0, 1'b1});
    enable = 1'b1;
    wait_accept(w);
    send(16'h0F0F, 16'hC3A5, w);
    check("bp_wait_long", {31'd0, (w >= 100)}, 32'd1);
    wait_fs("std_frame3");
    repeat (10) @(negedge clk);
    enable = 1'b0;
    check_tail("std_stop", 3'b110, 3'b001, 3'b001, 3'b101, 3'b101);

    // Asynchronous reset mid-frame with the holding register full
    ws_align = 1'b1;
    send(16'h1234, 16'h5678, w);
    @(negedge clk);
    enable = 1'b1;
    send(16'hABCD, 16'hEF01, w);
    repeat (50) @(negedge clk);
    check("pre_rst_ready", {31'd0, din_ready}, 32'd0);
    check("pre_rst_running", {31'd0, (i2s_clk | i2s_ws | i2s_din) !== 1'bx}, 32'd1);
    #2;
    rst    = 1'b1;
    enable = 1'b0;
    #1;
    check("midrst_outputs", {i2s_clk, i2s_ws, i2s_din, frame_start, underrun}, 5'b00000);
    check("midrst_ready", {31'd0, din_ready}, 32'd1);
    $display("mid-frame reset applied");
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (100) begin
      @(negedge clk);
      check("idle_quiet", {i2s_clk, i2s_ws, i2s_din, frame_start, underrun, din_ready}, 6'b000001);
    end

    check("sb_empty", sb.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    n_err++;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $fatal(1, "watchdog expired");
  end

endmodule
